// File: rtl/fma_pkg.sv
// fma_pkg: shared round-mode, flag and pipeline types for the fma16 back end
package fma_pkg;
  localparam int FMA_NF = 10;
  localparam int FMA_NE = 5;
  typedef enum logic [1:0] {RZ = 2'b00, RNE = 2'b01, RM = 2'b10, RP = 2'b11} round_mode_e;
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam int EMAX = 2**FMA_NE - 1;
  localparam logic [FMA_NE+FMA_NF-1:0] MAXFINITE = {{(FMA_NE-1){1'b1}}, 1'b0, {FMA_NF{1'b1}}};
  typedef struct packed {
    logic                     sign;
    logic [FMA_NE+1:0]        exp;
    logic [FMA_NF-1:0]        frac;
    logic                     nx;
    logic                     zero;
    logic                     inc;
    round_mode_e              mode;
    logic                     sp_valid;
    logic [FMA_NE+FMA_NF:0]   sp_result;
    logic                     sp_invalid;
  } s1_t;
  function automatic logic [3:0] mk_flags(input logic nv, input logic of, input logic uf, input logic nx);
    mk_flags = '0;
    mk_flags[FLAG_NV] = nv;
    mk_flags[FLAG_OF] = of;
    mk_flags[FLAG_UF] = uf;
    mk_flags[FLAG_NX] = nx;
  endfunction
endpackage

// File: rtl/fma_round_decide.sv
// fma_round_decide: round-increment and inexact decision; RM/RP only with FMA_ALL_ROUND_MODES_EN
module fma_round_decide
  import fma_pkg::*;
(
  input  logic        l,
  input  logic        g,
  input  logic        s,
  input  logic        sign,
  input  round_mode_e mode,
  output logic        inc,
  output logic        nx
);
  assign nx = g | s;
`ifdef FMA_ALL_ROUND_MODES_EN
  assign inc = mode == RNE ? g & (l | s) :
               mode == RM  ? sign & (g | s) :
               mode == RP  ? ~sign & (g | s) : 1'b0;
`else
  logic unused_in;
  assign unused_in = mode[1] ^ sign;
  assign inc = mode[0] & g & (l | s);
`endif
endmodule

// File: rtl/fma_round_pack.sv
// fma_round_pack: two-stage round/pack of the fma16 sum with flags; modes set by FMA_ALL_ROUND_MODES_EN
module fma_round_pack
  import fma_pkg::*;
#(
  parameter int NF = FMA_NF,
  parameter int NE = FMA_NE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             m_sign,
  input  logic [NE+1:0]    m_exp,
  input  logic [4*NF+5:0]  m_shifted,
  input  logic             a_sticky,
  input  logic             sp_valid,
  input  logic [NE+NF:0]   sp_result,
  input  logic             sp_invalid,
  input  logic [1:0]       roundmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NE+NF:0]   result,
  output logic [3:0]       flags
);
  s1_t s1, s1_n;
  logic s1_valid, s2_valid, adv1, adv2, inc1, nx1, ovf_inf, nx_exc, ovf, unf;
  logic [NF:0] frac_r;
  logic [NE+2:0] exp_r;
  logic [NE+NF:0] res_n;
  logic [3:0] flags_n;
  assign adv2 = ~s2_valid | out_ready;
  assign adv1 = ~s1_valid | adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;
  fma_round_decide u_dec (
    .l(m_shifted[2*NF+2]), .g(m_shifted[2*NF+1]), .s(|m_shifted[2*NF:0] | a_sticky),
    .sign(m_sign), .mode(round_mode_e'(roundmode)), .inc(inc1), .nx(nx1)
  );
  assign s1_n = '{sign: m_sign, exp: m_exp, frac: m_shifted[3*NF+1:2*NF+2], nx: nx1,
                  zero: ~|{m_shifted, a_sticky}, inc: inc1, mode: round_mode_e'(roundmode),
                  sp_valid: sp_valid, sp_result: sp_result, sp_invalid: sp_invalid};
  // An all-ones L/G/S rounds away from zero exactly when overflow must saturate to infinity
  fma_round_decide u_ovf (
    .l(1'b1), .g(1'b1), .s(1'b1), .sign(s1.sign), .mode(s1.mode), .inc(ovf_inf), .nx(nx_exc)
  );
  assign frac_r = {1'b0, s1.frac} + {{NF{1'b0}}, s1.inc};
  assign exp_r = {s1.exp[NE+1], s1.exp} + {{(NE+2){1'b0}}, frac_r[NF]};
  assign ovf = ~exp_r[NE+2] & (exp_r[NE+1:0] >= (NE+2)'(EMAX));
  assign unf = s1.exp[NE+1] | ~|s1.exp;
  assign res_n = s1.sp_valid ? s1.sp_result :
                 (s1.zero | unf) ? {s1.sign, {(NE+NF){1'b0}}} :
                 ovf ? (ovf_inf ? {s1.sign, {NE{1'b1}}, {NF{1'b0}}} : {s1.sign, MAXFINITE}) :
                 {s1.sign, exp_r[NE-1:0], frac_r[NF-1:0]};
  assign flags_n = s1.sp_valid ? mk_flags(s1.sp_invalid, 1'b0, 1'b0, 1'b0) :
                   s1.zero ? 4'b0000 :
                   unf ? mk_flags(1'b0, 1'b0, 1'b1, nx_exc) :
                   ovf ? mk_flags(1'b0, 1'b1, 1'b0, nx_exc) :
                   mk_flags(1'b0, 1'b0, 1'b0, s1.nx);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1 <= '0;
      result <= '0;
      flags <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= s1_n;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= res_n;
          flags <= flags_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_fma_round_pack.sv
// tb_fma_round_pack: directed vectors against a remainder-based rounding model and scoreboard
module tb_fma_round_pack;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, m_sign = 0, a_sticky = 0;
  logic sp_valid = 0, sp_invalid = 0, out_valid, out_ready = 1;
  logic [6:0] m_exp = 0;
  logic [45:0] m_shifted = 0;
  logic [15:0] sp_result = 0, result;
  logic [1:0] roundmode = 0;
  logic [3:0] flags;
  int checks = 0, errors = 0;
  logic [19:0] q[$];
  logic stall_prev = 0;
  logic [15:0] prev_r;
  logic [3:0] prev_f;
  localparam logic [45:0] ONE = 46'h1 << 32;
  localparam logic [45:0] GB = 46'h1 << 21;
  localparam logic [45:0] LB = 46'h1 << 22;
  localparam logic [45:0] FMAX = 46'h3FF << 22;

  fma_round_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .m_sign(m_sign),
    .m_exp(m_exp), .m_shifted(m_shifted), .a_sticky(a_sticky), .sp_valid(sp_valid),
    .sp_result(sp_result), .sp_invalid(sp_invalid), .roundmode(roundmode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] model(input logic sg, input logic [6:0] e, input logic [45:0] sh,
      input logic st, input logic [1:0] mode, input logic spv, input logic [15:0] spr, input logic spi);
    longint v, frac, rem, half;
    int ex;
    logic [1:0] md;
    bit inexact, above, tie, up, inf;
    if (spv) return {spr, spi, 3'b000};
    if (sh == 0 && !st) return {sg, 15'h0, 4'h0};
    ex = $signed(e);
    if (ex <= 0) return {sg, 15'h0, 4'b0011};
    v = longint'(sh);
    frac = (v >> 22) % 1024;
    rem = v % (64'sd1 << 22);
    half = 64'sd1 << 21;
    inexact = rem != 0 || st;
    above = rem > half || (rem == half && st);
    tie = rem == half && !st;
`ifdef FMA_ALL_ROUND_MODES_EN
    md = mode;
`else
    md = {1'b0, mode[0]};
`endif
    case (md)
      2'd0: up = 0;
      2'd1: up = above || (tie && frac % 2 == 1);
      2'd2: up = sg && inexact;
      default: up = !sg && inexact;
    endcase
    frac = frac + longint'(up);
    if (frac == 1024) begin
      frac = 0;
      ex++;
    end
    if (ex >= 31) begin
      inf = md == 2'd1 || (md == 2'd2 && sg) || (md == 2'd3 && !sg);
      return inf ? {sg, 5'h1F, 10'h000, 4'b0101} : {sg, 5'h1E, 10'h3FF, 4'b0101};
    end
    return {sg, 5'(ex), 10'(frac), 3'b000, inexact};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_prev = 0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || result !== prev_r || flags !== prev_f) begin
          errors++;
          $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b", out_valid, result, flags, prev_r, prev_f);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h/%b want nothing", result, flags);
        end else if ({result, flags} !== q[0]) begin
          errors++;
          $display("FAIL out: got %h/%b want %h/%b", result, flags, q[0][19:4], q[0][3:0]);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready)
        q.push_back(model(m_sign, m_exp, m_shifted, a_sticky, roundmode, sp_valid, sp_result, sp_invalid));
      stall_prev = out_valid && !out_ready;
      prev_r = result;
      prev_f = flags;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic sg, input logic [6:0] e, input logic [45:0] sh, input logic st,
      input logic [1:0] md, input logic spv, input logic [15:0] spr, input logic spi);
    bit ok, done;
    done = 0;
    m_sign = sg; m_exp = e; m_shifted = sh; a_sticky = st; roundmode = md;
    sp_valid = spv; sp_result = spr; sp_invalid = spi; in_valid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      done = ok;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
      in_valid = 0;
    end
  endtask

  task automatic vec(input string name, input logic sg, input logic [6:0] e, input logic [45:0] sh,
      input logic st, input logic [1:0] md, input logic [15:0] er, input logic [3:0] ef);
    check({"model_", name}, 32'(model(sg, e, sh, st, md, 1'b0, 16'h0, 1'b0)), 32'({er, ef}));
    send(sg, e, sh, st, md, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    reset = 0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    vec("one", 0, 7'd15, ONE, 0, 2'b01, 16'h3C00, 4'b0000);
    in_valid = 0;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_result", 32'(result), 32'h3C00);
    check("lat_flags", 32'(flags), 32'h0);
    vec("tie_even", 0, 7'd15, ONE | GB, 0, 2'b01, 16'h3C00, 4'b0001);
    vec("tie_odd", 0, 7'd15, ONE | LB | GB, 0, 2'b01, 16'h3C02, 4'b0001);
    vec("carry_rne", 0, 7'd15, ONE | FMAX | GB, 0, 2'b01, 16'h4000, 4'b0001);
    vec("carry_rz", 0, 7'd15, ONE | FMAX | GB, 0, 2'b00, 16'h3FFF, 4'b0001);
    vec("ovf_rz", 0, 7'd31, ONE, 0, 2'b00, 16'h7BFF, 4'b0101);
    vec("ovf_rne", 0, 7'd31, ONE, 0, 2'b01, 16'h7C00, 4'b0101);
    vec("ovf_carry", 0, 7'd30, ONE | FMAX | GB, 0, 2'b01, 16'h7C00, 4'b0101);
    vec("max_exact", 0, 7'd30, ONE | FMAX, 0, 2'b01, 16'h7BFF, 4'b0000);
    vec("unf", 0, 7'd0, ONE, 0, 2'b01, 16'h0000, 4'b0011);
    vec("unf_neg", 1, 7'h7E, ONE | GB, 0, 2'b00, 16'h8000, 4'b0011);
    vec("zero", 1, 7'd0, 46'h0, 0, 2'b01, 16'h8000, 4'b0000);
    vec("sticky_rne", 0, 7'd15, ONE | GB, 1, 2'b01, 16'h3C01, 4'b0001);
`ifdef FMA_ALL_ROUND_MODES_EN
    vec("ovf_rm_neg", 1, 7'd31, ONE, 0, 2'b10, 16'hFC00, 4'b0101);
    vec("ovf_rm_pos", 0, 7'd31, ONE, 0, 2'b10, 16'h7BFF, 4'b0101);
    vec("ovf_rp_neg", 1, 7'd31, ONE, 0, 2'b11, 16'hFBFF, 4'b0101);
    vec("rp_sticky", 0, 7'd15, ONE, 1, 2'b11, 16'h3C01, 4'b0001);
    vec("rm_sticky", 1, 7'd15, ONE, 1, 2'b10, 16'hBC01, 4'b0001);
`else
    vec("ovf_rm_neg", 1, 7'd31, ONE, 0, 2'b10, 16'hFBFF, 4'b0101);
    vec("ovf_rp_pos", 0, 7'd31, ONE, 0, 2'b11, 16'h7C00, 4'b0101);
    vec("rp_sticky", 0, 7'd15, ONE, 1, 2'b11, 16'h3C00, 4'b0001);
    vec("rm_tie", 1, 7'd15, ONE | LB | GB, 0, 2'b10, 16'hBC01, 4'b0001);
`endif
    check("model_special", 32'(model(0, 7'd0, 46'h0, 0, 2'b01, 1'b1, 16'h7E00, 1'b1)), 32'({16'h7E00, 4'b1000}));
    send(0, 7'd0, 46'h0, 0, 2'b01, 1'b1, 16'h7E00, 1'b1);
    in_valid = 0;
    drain();
    out_ready = 0;
    fork
      begin
        vec("bp0", 0, 7'd15, ONE, 0, 2'b01, 16'h3C00, 4'b0000);
        vec("bp1", 0, 7'd15, ONE | LB | GB, 0, 2'b01, 16'h3C02, 4'b0001);
        check("bp_full", 32'(in_ready), 32'd0);
        vec("bp2", 0, 7'd15, ONE | FMAX | GB, 0, 2'b01, 16'h4000, 4'b0001);
        vec("bp3", 1, 7'd0, ONE, 0, 2'b01, 16'h8000, 4'b0011);
        in_valid = 0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    vec("rs0", 0, 7'd20, ONE, 0, 2'b01, 16'h5000, 4'b0000);
    vec("rs1", 0, 7'd21, ONE, 0, 2'b01, 16'h5400, 4'b0000);
    in_valid = 0;
    check("rs_inflight", 32'(out_valid), 32'd1);
    #1;
    reset = 1;
    #1;
    check("rs_async", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    out_ready = 1;
    #1;
    check("rs_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rs_flushed", 32'(out_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
